// File: rtl/odd_pkg.sv
// odd_pkg: shared sample width, default accept range and the odd-in-range qualifier
// Contents: SAMPLE_W, sample_t, LO_DEF/HI_DEF, is_odd_in_range(value, lo, hi)
package odd_pkg;
  localparam int SAMPLE_W = 7;
  typedef logic [SAMPLE_W-1:0] sample_t;
  localparam sample_t LO_DEF = 7'd34;
  localparam sample_t HI_DEF = 7'd65;
  function automatic logic is_odd_in_range(sample_t value, sample_t lo, sample_t hi);
    return value[0] && value >= lo && value <= hi;
  endfunction
endpackage

// File: rtl/odd_sample_buffer_if.sv
// odd_sample_buffer_if: sample input stream plus valid/ready output port
// Signals: in_valid, in_data (producer -> buffer); out_valid, out_data, out_ready (buffer <-> consumer)
// Modports: master drives samples and out_ready, slave is the buffer
interface odd_sample_buffer_if;
  import odd_pkg::*;
  logic in_valid;
  sample_t in_data;
  logic out_valid;
  logic out_ready;
  sample_t out_data;
  modport master(output in_valid, in_data, out_ready, input out_valid, out_data);
  modport slave(input in_valid, in_data, out_ready, output out_valid, out_data);
endinterface

// File: rtl/odd_fifo.sv
// odd_fifo: synchronous first-word-fall-through FIFO with wrap-bit pointers
// Ports: clk, rst (sync, active-high), push/wdata in, pop in, rdata out (0 when empty), full, empty
// Caller must not push when full without a same-cycle pop, nor pop when empty.
module odd_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  assign empty = wptr == rptr;
  assign full = wptr[AW] != rptr[AW] && wptr[AW-1:0] == rptr[AW-1:0];
  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop) rptr <= rptr + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) if (push) mem[wptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/odd_sample_buffer.sv
// odd_sample_buffer: qualifies odd in-range samples, queues them in a FWFT FIFO, keeps quality stats
// Ports: clk, rst (sync, active-high), bus (odd_sample_buffer_if.slave),
//        acc_cnt/rej_cnt/drop_cnt (saturating), drop_flag (sticky), min_val/max_val of accepted samples
// Build option: ODD_BUF_STATS_EN builds counters and min/max; otherwise those outputs are tied to 0.
module odd_sample_buffer import odd_pkg::*; #(
  parameter sample_t LO = LO_DEF,
  parameter sample_t HI = HI_DEF,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  odd_sample_buffer_if.slave bus,
  output logic [CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0] rej_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             drop_flag,
  output sample_t          min_val,
  output sample_t          max_val
);
  logic qual, push, pop, full, empty, drop;
  sample_t head;
  assign qual = bus.in_valid && is_odd_in_range(bus.in_data, LO, HI);
  // out_valid comes from registered pointers only, so pop never loops back into out_valid
  assign pop = !empty && bus.out_ready;
  assign push = qual && (!full || pop);
  assign drop = qual && full && !pop;
  assign bus.out_valid = !empty;
  assign bus.out_data = head;
  odd_fifo #(.DEPTH(DEPTH), .W(SAMPLE_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .wdata(bus.in_data),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (rst) drop_flag <= 1'b0;
    else if (drop) drop_flag <= 1'b1;
  end
`ifdef ODD_BUF_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt <= '0;
      rej_cnt <= '0;
      drop_cnt <= '0;
      min_val <= '1;
      max_val <= '0;
    end else begin
      if (push && !(&acc_cnt)) acc_cnt <= acc_cnt + CNT_W'(1);
      if (bus.in_valid && !qual && !(&rej_cnt)) rej_cnt <= rej_cnt + CNT_W'(1);
      if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + CNT_W'(1);
      if (push) begin
        min_val <= bus.in_data < min_val ? bus.in_data : min_val;
        max_val <= bus.in_data > max_val ? bus.in_data : max_val;
      end
    end
  end
`else
  assign acc_cnt = '0;
  assign rej_cnt = '0;
  assign drop_cnt = '0;
  assign min_val = '0;
  assign max_val = '0;
`endif
endmodule

// File: tb/tb_odd_sample_buffer.sv
// tb_odd_sample_buffer: scoreboard bench for odd_sample_buffer (stats expectations follow ODD_BUF_STATS_EN)
module tb_odd_sample_buffer;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  odd_sample_buffer_if bus();
  logic [CNT_W-1:0] acc_cnt, rej_cnt, drop_cnt;
  logic drop_flag;
  logic [6:0] min_val, max_val;
  odd_sample_buffer #(.LO(7'd34), .HI(7'd65), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .acc_cnt(acc_cnt),
    .rej_cnt(rej_cnt),
    .drop_cnt(drop_cnt),
    .drop_flag(drop_flag),
    .min_val(min_val),
    .max_val(max_val)
  );
  int n_chk = 0;
  int n_pass = 0;
  int n_out = 0;
  int last_out = -1;
  int exp_q[$];
  bit popped;
  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  function automatic int st(int v);
`ifdef ODD_BUF_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction
  task automatic stats(string tag, int a, int r, int d, int df, int mn, int mx);
    chk({tag, "_acc"}, int'(acc_cnt), st(a));
    chk({tag, "_rej"}, int'(rej_cnt), st(r));
    chk({tag, "_drop"}, int'(drop_cnt), st(d));
    chk({tag, "_dflag"}, int'(drop_flag), df);
    chk({tag, "_min"}, int'(min_val), st(mn));
    chk({tag, "_max"}, int'(max_val), st(mx));
  endtask
  // Scoreboard: samples enter the expected queue as they are driven, leave when the consumer takes them
  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else begin
      popped = 1'b0;
      chk("out_valid", int'(bus.out_valid), int'(exp_q.size() != 0));
      if (exp_q.size() != 0 && bus.out_ready) begin
        last_out = exp_q.pop_front();
        chk("out_data", int'(bus.out_data), last_out);
        n_out++;
        popped = 1'b1;
      end
      if (bus.in_valid && bus.in_data >= 7'd34 && bus.in_data <= 7'd65 && bus.in_data[0]
          && (exp_q.size() < DEPTH || popped))
        exp_q.push_back(int'(bus.in_data));
    end
  end
  task automatic drive(bit v, int d, bit rdy);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.in_data = 7'(d);
    bus.out_ready = rdy;
  endtask
  task automatic idle(int n, bit rdy);
    repeat (n) drive(1'b0, 0, rdy);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  int s1[6] = '{33, 34, 35, 65, 66, 67};
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    stats("rst", 0, 0, 0, 0, 127, 0);
    n_out = 0;
    foreach (s1[i]) drive(1'b1, s1[i], 1'b1);
    idle(3, 1'b1);
    chk("s1_nout", n_out, 2);
    chk("s1_last", last_out, 65);
    stats("s1", 2, 4, 0, 0, 35, 65);
    do_reset();
    for (int i = 0; i < 9; i++) drive(1'b1, 35 + 2 * i, 1'b0);
    idle(1, 1'b0);
    chk("s2_held_valid", int'(bus.out_valid), 1);
    stats("s2", 8, 0, 1, 1, 35, 49);
    n_out = 0;
    idle(12, 1'b1);
    chk("s2_nout", n_out, 8);
    chk("s2_last", last_out, 49);
    chk("s2_sticky", int'(drop_flag), 1);
    do_reset();
    for (int i = 0; i < 8; i++) drive(1'b1, 35 + 2 * i, 1'b0);
    drive(1'b1, 41, 1'b1);
    drive(1'b1, 53, 1'b0);
    idle(1, 1'b0);
    stats("s3", 9, 0, 1, 1, 35, 49);
    n_out = 0;
    idle(12, 1'b1);
    chk("s3_nout", n_out, 8);
    chk("s3_last", last_out, 41);
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 37 + 2 * i, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 7'd45;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("s4_out_valid", int'(bus.out_valid), 0);
    stats("s4", 0, 0, 0, 0, 127, 0);
    n_out = 0;
    idle(3, 1'b1);
    chk("s4_nout", n_out, 0);
    for (int i = 0; i < 20; i++) drive(1'b1, 40, 1'b1);
    idle(1, 1'b1);
    stats("s5", 0, 15, 0, 0, 127, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
